// File: rtl/t_counter_pkg.sv
// Shared types and the next-count rule for the modulo up/down T flip-flop counter.
package t_counter_pkg;

  localparam int MAX_W = 16;

  typedef logic [MAX_W-1:0] cnt_t;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Out-of-range values (q > last) wrap to 0 going up and to last going down.
  function automatic cnt_t next_count(input cnt_t q, input logic up, input cnt_t last);
    if (up == DIR_UP)
      return (q < last) ? q + cnt_t'(1) : '0;
    else
      return ((q == '0) || (q > last)) ? last : q - cnt_t'(1);
  endfunction

endpackage

// File: rtl/t_counter_if.sv
// Control/data bundle of the counter: load/count controls in, registered count and carry out.
interface t_counter_if #(
  parameter int WIDTH = 4
) ();
  logic             EN;
  logic             UP;
  logic             LOAD;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] not_Q;
  logic             TC;

  modport master (output EN, UP, LOAD, D, input Q, not_Q, TC);
  modport slave  (input EN, UP, LOAD, D, output Q, not_Q, TC);
endinterface

// File: rtl/t_counter_tff.sv
// Rising-edge T flip-flop with synchronous reset and parallel load (RST > LD > T).
module t_ff (
  input  logic CLK,
  input  logic RST,
  input  logic T,
  input  logic LD,
  input  logic LD_VAL,
  output logic Q,
  output logic not_Q
);
  logic r_q;
  logic r_nq;

  // The complement is its own register so not_Q never sees an inverter glitch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q  <= 1'b0;
      r_nq <= 1'b1;
    end else if (LD) begin
      r_q  <= LD_VAL;
      r_nq <= ~LD_VAL;
    end else if (T) begin
      r_q  <= ~r_q;
      r_nq <= ~r_nq;
    end
  end

  assign Q     = r_q;
  assign not_Q = r_nq;
endmodule

// File: rtl/t_counter.sv
// Synchronous modulo-MOD up/down counter built from one T flip-flop per bit, with cascadable TC.
module t_counter
  import t_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic    CLK,
  input  logic    RST,
  t_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

  generate
    if ((WIDTH < 1) || (WIDTH > MAX_W) || (MOD < 2) || (MOD > (1 << WIDTH))) begin : g_bad_param
      $error("t_counter: illegal WIDTH/MOD combination");
    end
  endgenerate

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_nq;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_t;
  logic             w_at_end;

  assign w_next = WIDTH'(next_count(cnt_t'(w_q), bus.UP, cnt_t'(LAST)));

  // Toggle exactly the bits that differ between the current and next count.
  assign w_t = bus.EN ? (w_q ^ w_next) : '0;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      t_ff u_ff (
        .CLK    (CLK),
        .RST    (RST),
        .T      (w_t[i]),
        .LD     (bus.LOAD),
        .LD_VAL (bus.D[i]),
        .Q      (w_q[i]),
        .not_Q  (w_nq[i])
      );
    end
  endgenerate

  assign w_at_end  = bus.UP ? (w_q == LAST) : (w_q == '0);
  assign bus.TC    = ~RST & bus.EN & ~bus.LOAD & w_at_end;
  assign bus.Q     = w_q;
  assign bus.not_Q = w_nq;
endmodule
